// File: rtl/anc_tap_sequencer_if.sv
// anc_tap_sequencer_if
//  Bundles the sample-in handshake and the tap-out stream of the ANC delay-path
//  sequencer.
//  Signals:
//   sample_in / sample_valid / sample_ready : one reference sample per handshake
//   tap_data / tap_idx / tap_valid / tap_last / tap_ready : tap stream to the LMS MAC
//  Modports:
//   master : the environment. It drives samples and consumes taps.
//   slave  : the sequencer itself.
interface anc_tap_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int TAPS   = 16
);
    localparam int ADDR_W = $clog2(TAPS);

    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] tap_data;
    logic [ADDR_W-1:0] tap_idx;
    logic              tap_valid;
    logic              tap_last;
    logic              tap_ready;

    modport master (
        output sample_in, sample_valid, tap_ready,
        input  sample_ready, tap_data, tap_idx, tap_valid, tap_last
    );

    modport slave (
        input  sample_in, sample_valid, tap_ready,
        output sample_ready, tap_data, tap_idx, tap_valid, tap_last
    );
endinterface

// File: rtl/anc_tap_sequencer.sv
// anc_tap_sequencer
//  Delay-line controller for the ANC adaptive filter. TAPS reference samples are
//  kept in a circular buffer. Each accepted sample is streamed back out to the
//  LMS MAC as TAPS delayed taps x[n-k], newest first (k = 0 .. TAPS-1).
//  Ports:
//   clk  : system clock. All logic is on posedge.
//   rst  : synchronous, active-high reset.
//   bus  : anc_tap_sequencer_if.slave. Carries the sample handshake in and the
//          tap stream out.
//  Every output is registered. The stream holds stable while tap_ready is low.
module anc_tap_sequencer #(
    parameter int DATA_W = 64,
    parameter int TAPS   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    anc_tap_sequencer_if.slave     bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(TAPS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] np_reg;          // slot holding the newest sample
    logic [ADDR_W-1:0] k_reg;           // tap currently presented
    logic [DATA_W-1:0] tap_data_reg;
    logic              tap_valid_reg;
    logic              tap_last_reg;
    logic              sample_ready_reg;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] k_next;
    logic [ADDR_W-1:0] rd_ptr;
    logic              accept;
    logic [DATA_W-1:0] entry_rd [TAPS];

    always_comb begin
        wr_ptr = np_reg + ADDR_W'(1);
        k_next = k_reg + ADDR_W'(1);
        // Both pointers wrap through ADDR_W-bit natural overflow.
        rd_ptr = np_reg - k_next;
        accept = (state_reg == IDLE) && bus.sample_valid;
    end

    // The buffer is built from registers, not RAM, because reset has to clear
    // every entry. Slots that were never written must read back as zero.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (accept && (wr_ptr == ADDR_W'(gi))) begin
                    entry_reg <= bus.sample_in;
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            np_reg           <= '0;
            k_reg            <= '0;
            tap_data_reg     <= '0;
            tap_valid_reg    <= 1'b0;
            tap_last_reg     <= 1'b0;
            sample_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.sample_valid) begin
                        // Tap 0 is the sample being written on this edge. Take it
                        // straight from the input and skip the buffer.
                        np_reg           <= wr_ptr;
                        k_reg            <= '0;
                        tap_data_reg     <= bus.sample_in;
                        tap_valid_reg    <= 1'b1;
                        tap_last_reg     <= 1'b0;
                        sample_ready_reg <= 1'b0;
                        state_reg        <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.tap_ready) begin
                        if (k_reg == LAST_K) begin
                            state_reg        <= IDLE;
                            k_reg            <= '0;
                            tap_valid_reg    <= 1'b0;
                            tap_last_reg     <= 1'b0;
                            sample_ready_reg <= 1'b1;
                        end else begin
                            k_reg        <= k_next;
                            tap_data_reg <= entry_rd[rd_ptr];
                            tap_last_reg <= (k_next == LAST_K);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tap_data     = tap_data_reg;
    assign bus.tap_idx      = k_reg;
    assign bus.tap_valid    = tap_valid_reg;
    assign bus.tap_last     = tap_last_reg;
    assign bus.sample_ready = sample_ready_reg;
endmodule

// File: tb/tb_anc_tap_sequencer.sv
// tb_anc_tap_sequencer
//  Scoreboard bench for anc_tap_sequencer. Each accepted sample pushes its TAPS
//  expected taps, which come from a reference delay line. A negedge monitor pops
//  and compares one entry for every tap handshake.
module tb_anc_tap_sequencer;
    localparam int DATA_W = 64;
    localparam int TAPS   = 16;

    typedef struct {
        logic [63:0] data;
        int          idx;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mon_en;

    exp_t        sb_q [$];
    logic [63:0] m_buf [TAPS];
    int          m_np;

    anc_tap_sequencer_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus ();

    anc_tap_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < TAPS; i++) m_buf[i] = '0;
        m_np = 0;
    endtask

    // Called on the edge where the sample is accepted.
    task automatic model_push(input logic [63:0] d);
        exp_t e;
        m_np = (m_np + 1) % TAPS;
        m_buf[m_np] = d;
        for (int k = 0; k < TAPS; k++) begin
            e.data = m_buf[(m_np - k + TAPS) % TAPS];
            e.idx  = k;
            e.last = (k == TAPS - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_sample(input logic [63:0] d);
        int cyc;
        cyc = 0;
        while (!bus.sample_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("sready_before_send", 64'(bus.sample_ready), 64'd1);
        bus.sample_in    = d;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        model_push(d);
        $display("sample accepted data=%h", d);
        check_eq("sready_after_accept", 64'(bus.sample_ready), 64'd0);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || !bus.sample_ready) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("idle_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // The monitor checks tap_valid against the scoreboard every cycle. It pops
    // and compares on each handshake. A handshake that coincides with rst is
    // discarded by the DUT, so the monitor skips it too.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check_eq("tap_valid", 64'(bus.tap_valid), 64'(sb_q.size() > 0));
            if (bus.tap_valid && bus.tap_ready && sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("tap_data", bus.tap_data, e.data);
                check_eq("tap_idx", 64'(bus.tap_idx), 64'(e.idx));
                check_eq("tap_last", 64'(bus.tap_last), 64'(e.last));
                $display("tap idx=%0d data=%h last=%0b", bus.tap_idx, bus.tap_data, bus.tap_last);
            end
        end
    end

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.tap_ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        check_eq("rst_tap_valid", 64'(bus.tap_valid), 64'd0);
        check_eq("rst_tap_data", bus.tap_data, 64'd0);
        check_eq("rst_tap_idx", 64'(bus.tap_idx), 64'd0);
        check_eq("rst_tap_last", 64'(bus.tap_last), 64'd0);
        check_eq("rst_sready", 64'(bus.sample_ready), 64'd1);

        // 1: single sample, latency of sample_ready return
        send_sample(64'd1);
        cyc = 0;
        while (!bus.sample_ready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("sready_latency", 64'(cyc), 64'd16);
        wait_idle();

        // 2: history builds up, all-ones is carried bit-exact
        send_sample(64'd2);
        wait_idle();
        send_sample(64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();

        // 3: wrap of the circular buffer
        pulse_reset();
        for (int i = 1; i <= 17; i++) begin
            send_sample(64'(i));
            wait_idle();
        end

        // 4: backpressure for 3 cycles at idx 5
        send_sample(64'd18);
        cyc = 0;
        while (!(bus.tap_valid && bus.tap_idx == 4'd5) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.tap_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check_eq("stall_idx", 64'(bus.tap_idx), 64'd5);
            check_eq("stall_valid", 64'(bus.tap_valid), 64'd1);
            check_eq("stall_data", bus.tap_data, sb_q.size() > 0 ? sb_q[0].data : 64'hX);
            @(posedge clk); #1;
        end
        bus.tap_ready = 1'b1;
        wait_idle();

        // 5: sample_valid held during STREAM must be ignored
        send_sample(64'd19);
        bus.sample_in    = 64'hDEAD;
        bus.sample_valid = 1'b1;
        for (int s = 0; s < TAPS - 1; s++) begin
            check_eq("sready_stream", 64'(bus.sample_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.sample_valid = 1'b0;
        wait_idle();
        send_sample(64'd20);
        wait_idle();

        // 6: reset in the middle of a stream
        send_sample(64'd21);
        cyc = 0;
        while (!(bus.tap_valid && bus.tap_idx == 4'd7) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("reach_idx7", 64'(bus.tap_idx), 64'd7);
        pulse_reset();
        check_eq("midrst_tap_valid", 64'(bus.tap_valid), 64'd0);
        check_eq("midrst_sready", 64'(bus.sample_ready), 64'd1);
        send_sample(64'hAA);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
